// File: rtl/conv_pkg.sv
// Shared defaults, FSM state type and magnitude helper for the convolution
// accumulate blocks (x and y gradient paths).
package conv_pkg;

  localparam int CONV_A_W     = 5;
  localparam int CONV_B_W     = 5;
  localparam int CONV_ACC_W   = 12;
  localparam int CONV_RUN_LEN = 8;
  localparam int CONV_TIMEOUT = 15;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // |v| clipped to the largest positive value of the narrower magnitude field
  function automatic logic [CONV_ACC_W-2:0] abs_sat(input logic signed [CONV_ACC_W-1:0] v);
    logic [CONV_ACC_W-1:0] m;
    m = v[CONV_ACC_W-1] ? -v : v;
    if (m[CONV_ACC_W-1])
      return '1;
    else
      return m[CONV_ACC_W-2:0];
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered signed multiply followed by a wrapping accumulator; clr zeroes
// both pipeline stages so a new window starts from a clean sum.
module conv_mac
  import conv_pkg::*;
#(
  parameter int A_W   = CONV_A_W,
  parameter int B_W   = CONV_B_W,
  parameter int ACC_W = CONV_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;
  logic signed [P_W-1:0] p_reg;

  assign a_ext = {{B_W{a[A_W-1]}}, a};
  assign b_ext = {{A_W{b[B_W-1]}}, b};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      p_reg <= '0;
      acc   <= '0;
    end else begin
      p_reg <= a_ext * b_ext;
      acc   <= acc + {{(ACC_W-P_W){p_reg[P_W-1]}}, p_reg};
    end
  end

endmodule

// File: rtl/x_conv_accumulate.sv
// Gx accumulate stage: sums the six products of a 3x3 window, latches the
// signed sum and its magnitude, and holds them under a valid/ack handshake.
//
//   state | meaning
//   IDLE  | waiting for calc_enable; stray calc_done flags seq_error
//   RUN   | window in flight; run_cnt counts cycles since entry
module x_conv_accumulate
  import conv_pkg::*;
#(
  parameter int A_W     = CONV_A_W,
  parameter int B_W     = CONV_B_W,
  parameter int ACC_W   = CONV_ACC_W,
  parameter int RUN_LEN = CONV_RUN_LEN,
  parameter int TIMEOUT = CONV_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             calc_enable,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             calc_done,
  input  logic             result_ack,
  output logic [ACC_W-1:0] g_sum,
  output logic [ACC_W-2:0] g_abs,
  output logic             result_valid,
  output logic             overrun,
  output logic             seq_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                   state;
  logic [CNT_W-1:0]         run_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic                     clr;
  logic                     latch;

  assign clr   = (state == IDLE) && calc_enable;
  assign latch = (state == RUN) && calc_done;

  conv_mac #(
    .A_W   (A_W),
    .B_W   (B_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .a   (a),
    .b   (b),
    .acc (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      run_cnt      <= '0;
      g_sum        <= '0;
      g_abs        <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      seq_error    <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      seq_error <= 1'b0;

      case (state)
        IDLE: begin
          if (calc_enable) begin
            run_cnt <= '0;
            state   <= RUN;
          end else if (calc_done) begin
            seq_error <= 1'b1;
          end
        end
        RUN: begin
          run_cnt <= run_cnt + 1'b1;
          // calc_done wins over timeout; a short or long window still latches
          if (calc_done) begin
            state <= IDLE;
            g_sum <= acc;
            g_abs <= abs_sat(acc);
            if (run_cnt != CNT_W'(RUN_LEN - 1))
              seq_error <= 1'b1;
          end else if (run_cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= IDLE;
            seq_error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (latch) begin
        result_valid <= 1'b1;
        overrun      <= result_valid && !result_ack;
      end else if (result_ack) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_x_conv_accumulate.sv
// Scenario bench for x_conv_accumulate: windows are driven cycle by cycle,
// expected results are queued at calc_done and compared on the next cycle.
module tb_x_conv_accumulate;

  localparam int A_W     = 5;
  localparam int B_W     = 5;
  localparam int ACC_W   = 12;
  localparam int RUN_LEN = 8;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [ACC_W-2:0] abs_v;
    bit               seq;
    bit               ovr;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             calc_enable;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             calc_done;
  logic             result_ack;
  logic [ACC_W-1:0] g_sum;
  logic [ACC_W-2:0] g_abs;
  logic             result_valid;
  logic             overrun;
  logic             seq_error;

  exp_t sb[$];
  int   n_chk;
  int   n_pass;
  bit   model_valid;

  x_conv_accumulate #(
    .A_W     (A_W),
    .B_W     (B_W),
    .ACC_W   (ACC_W),
    .RUN_LEN (RUN_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .calc_enable  (calc_enable),
    .a            (a),
    .b            (b),
    .calc_done    (calc_done),
    .result_ack   (result_ack),
    .g_sum        (g_sum),
    .g_abs        (g_abs),
    .result_valid (result_valid),
    .overrun      (overrun),
    .seq_error    (seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one window; products from cycle k are in the sum latched at cycle k+2 or later.
  task automatic run_window(input int av[6], input int bv[6], input int done_at,
                            input bit ack_at_done, input bit reen3);
    int   s;
    int   m;
    int   t;
    exp_t e;
    s = 0;
    for (int i = 0; i < 6; i++)
      if (i + 1 <= done_at - 2) s += av[i] * bv[i];
    m = (s < 0) ? -s : s;
    if (m > 2047) m = 2047;
    e.sum   = s[ACC_W-1:0];
    e.abs_v = m[ACC_W-2:0];
    e.seq   = (done_at != RUN_LEN);
    e.ovr   = model_valid && !ack_at_done;

    calc_enable = 1'b1; a = '0; b = '0;
    tick();
    for (int c = 1; c <= done_at; c++) begin
      calc_enable = reen3 && (c == 3);
      if (c <= 6) begin
        t = av[c-1]; a = t[A_W-1:0];
        t = bv[c-1]; b = t[B_W-1:0];
      end else begin
        a = '0; b = '0;
      end
      calc_done  = (c == done_at);
      result_ack = ack_at_done && (c == done_at);
      if (c == done_at) sb.push_back(e);
      tick();
    end
    calc_enable = 1'b0; calc_done = 1'b0; result_ack = 1'b0; a = '0; b = '0;
    model_valid = 1'b1;
  endtask

  task automatic do_ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    model_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; calc_enable = 1'b0; calc_done = 1'b0; result_ack = 1'b0; a = '0; b = '0;
    model_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_chk++;
    if ({g_sum, g_abs, result_valid, overrun, seq_error} !== '0) begin
      $display("FAIL reset: got sum=%h abs=%h v=%b ovr=%b serr=%b, want all zero",
               g_sum, g_abs, result_valid, overrun, seq_error);
    end else n_pass++;
  endtask

  task automatic check_result(input string name);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    if ({g_sum, g_abs, result_valid, overrun, seq_error} !== {e.sum, e.abs_v, 1'b1, e.ovr, e.seq}) begin
      $display("FAIL %s: got sum=%0d abs=%0d v=%b ovr=%b serr=%b, want sum=%0d abs=%0d v=1 ovr=%b serr=%b",
               name, $signed(g_sum), g_abs, result_valid, overrun, seq_error,
               $signed(e.sum), e.abs_v, e.ovr, e.seq);
    end else n_pass++;
  endtask

  task automatic test_sums();
    int av[6];
    int bv[6];
    av = '{1, 2, 1, -1, -2, -1};
    bv = '{15, 15, 15, 0, 0, 0};
    run_window(av, bv, 8, 1'b0, 1'b0);
    check_result("sum_pos60");
    n_chk++;
    if (g_sum !== 12'd60) $display("FAIL sum_pos60_const: got %h want 03c", g_sum);
    else n_pass++;
    do_ack();
    n_chk++;
    if (result_valid !== 1'b0) $display("FAIL ack_clear: got v=%b want 0", result_valid);
    else n_pass++;

    bv = '{0, 0, 0, 15, 15, 15};
    run_window(av, bv, 8, 1'b0, 1'b0);
    check_result("sum_neg60");
    n_chk++;
    if (g_sum !== 12'hFC4 || g_abs !== 11'd60)
      $display("FAIL sum_neg60_const: got sum=%h abs=%0d want fc4 60", g_sum, g_abs);
    else n_pass++;
    do_ack();

    av = '{-16, -16, -16, -16, -16, -16};
    bv = '{15, 15, 15, 15, 15, 15};
    run_window(av, bv, 8, 1'b0, 1'b0);
    check_result("sum_min");
    n_chk++;
    if (g_sum !== 12'hA60 || g_abs !== 11'd1440)
      $display("FAIL sum_min_const: got sum=%h abs=%0d want a60 1440", g_sum, g_abs);
    else n_pass++;
    do_ack();

    av = '{15, 15, 15, 15, 15, 15};
    run_window(av, bv, 8, 1'b0, 1'b0);
    check_result("sum_max");
    n_chk++;
    if (g_sum !== 12'd1350) $display("FAIL sum_max_const: got %0d want 1350", g_sum);
    else n_pass++;
    do_ack();
  endtask

  task automatic test_random();
    int av[6];
    int bv[6];
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 6; i++) begin
        av[i] = int'($urandom_range(31)) - 16;
        bv[i] = int'($urandom_range(15));
      end
      run_window(av, bv, 8, 1'b0, 1'b0);
      check_result("random_window");
      do_ack();
    end
  endtask

  task automatic test_back_to_back();
    int av[6];
    int bv[6];
    av = '{1, 2, 1, -1, -2, -1};
    bv = '{15, 15, 15, 0, 0, 0};
    run_window(av, bv, 8, 1'b0, 1'b0);
    check_result("b2b_first");
    bv = '{0, 0, 0, 15, 15, 15};
    run_window(av, bv, 8, 1'b0, 1'b0);
    check_result("b2b_overrun");
    tick();
    n_chk++;
    if (overrun !== 1'b0 || result_valid !== 1'b1)
      $display("FAIL overrun_pulse: got ovr=%b v=%b want ovr=0 v=1", overrun, result_valid);
    else n_pass++;
    av = '{15, 15, 15, 15, 15, 15};
    bv = '{15, 15, 15, 15, 15, 15};
    run_window(av, bv, 8, 1'b1, 1'b0);
    check_result("b2b_ack_at_latch");
    do_ack();
  endtask

  task automatic test_protocol();
    int av[6];
    int bv[6];
    logic [ACC_W-1:0] held;
    av = '{1, 2, 1, -1, -2, -1};
    bv = '{15, 15, 15, 0, 0, 0};
    run_window(av, bv, 8, 1'b0, 1'b1);
    check_result("reenable_ignored");
    do_ack();

    av = '{1, 2, 3, 4, 5, 6};
    bv = '{1, 1, 1, 1, 1, 1};
    run_window(av, bv, 5, 1'b0, 1'b0);
    check_result("early_done");
    do_ack();

    repeat (3) tick();
    held = g_sum;
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    n_chk++;
    if (seq_error !== 1'b1 || result_valid !== 1'b0 || g_sum !== held)
      $display("FAIL idle_done: got serr=%b v=%b sum=%h want serr=1 v=0 sum=%h",
               seq_error, result_valid, g_sum, held);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int first;
    int pulses;
    first = 0;
    pulses = 0;
    calc_enable = 1'b1;
    tick();
    calc_enable = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (seq_error) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    n_chk++;
    if (first != TIMEOUT || pulses != 1)
      $display("FAIL timeout: got first=%0d pulses=%0d want first=%0d pulses=1", first, pulses, TIMEOUT);
    else n_pass++;
    n_chk++;
    if (result_valid !== 1'b0) $display("FAIL timeout_valid: got v=%b want 0", result_valid);
    else n_pass++;
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    n_chk++;
    if (seq_error !== 1'b1 || result_valid !== 1'b0)
      $display("FAIL timeout_idle: got serr=%b v=%b want serr=1 v=0", seq_error, result_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int av[6];
    int bv[6];
    av = '{15, 15, 15, 15, 15, 15};
    bv = '{15, 15, 15, 15, 15, 15};
    run_window(av, bv, 8, 1'b0, 1'b0);
    check_result("pre_reset_window");
    calc_enable = 1'b1;
    tick();
    calc_enable = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      a = 5'd7; b = 5'd9;
      tick();
    end
    a = '0; b = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_valid = 1'b0;
    n_chk++;
    if ({g_sum, g_abs, result_valid, overrun, seq_error} !== '0)
      $display("FAIL reset_mid_run: got sum=%h abs=%h v=%b ovr=%b serr=%b, want all zero",
               g_sum, g_abs, result_valid, overrun, seq_error);
    else n_pass++;
    repeat (3) tick();
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    n_chk++;
    if (seq_error !== 1'b1 || result_valid !== 1'b0 || g_sum !== '0)
      $display("FAIL reset_then_done: got serr=%b v=%b sum=%h want serr=1 v=0 sum=000",
               seq_error, result_valid, g_sum);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_sums();
    test_random();
    test_back_to_back();
    test_protocol();
    test_timeout();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
